// File: rtl/printf_line_decoder.sv
// printf_line_decoder: parses "<tag> <decimal>\n" log lines into binary results, one result per line.
// Optional feature: define PRINTF_LINE_DECODER_SIGNED_EN to accept a leading '-' (two's-complement result).
module printf_line_decoder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_error,
  output logic [15:0]      line_count
);

  localparam int unsigned AW = WIDTH + 4;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [2:0] {TAG, SKIP, NUM, DRAIN, EMIT} state_t;

  state_t        state;
  logic [AW-1:0] acc;
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
  logic          sign;
  logic          need_digit;
`endif

  logic             is_digit;
  logic [AW-1:0]    acc_next;
  logic             ovf;
  logic             line_err;
  logic [WIDTH-1:0] emit_value;

  always_comb begin
    is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    // acc stays below 2^WIDTH, so acc*10+9 always fits in WIDTH+4 bits
    acc_next = (acc << 3) + (acc << 1) + AW'(in_byte[3:0]);
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
    ovf        = sign ? (acc_next > (AW'(1) << (WIDTH-1)))
                      : (acc_next >= (AW'(1) << (WIDTH-1)));
    line_err   = (state != NUM) || need_digit;
    emit_value = sign ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
`else
    ovf        = acc_next >= (AW'(1) << WIDTH);
    line_err   = (state != NUM);
    emit_value = acc[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= TAG;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_error  <= 1'b0;
      line_count <= '0;
      acc        <= '0;
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
      sign       <= 1'b0;
      need_digit <= 1'b0;
`endif
    end else begin
      case (state)
        EMIT: begin
          if (out_ready) begin
            state      <= TAG;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            line_count <= line_count + 16'd1;
            acc        <= '0;
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
            sign       <= 1'b0;
            need_digit <= 1'b0;
`endif
          end
        end
        default: begin
          if (in_valid && in_byte != CH_CR) begin
            // LF closes the line from any input state; only a completed NUM field is error-free
            if (in_byte == CH_LF) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_error <= line_err;
              out_value <= line_err ? '0 : emit_value;
            end else begin
              case (state)
                TAG: if (in_byte == CH_SP) state <= SKIP;
                SKIP: begin
                  if (is_digit) begin
                    acc   <= AW'(in_byte[3:0]);
                    state <= NUM;
                  end else if (in_byte == CH_MINUS) begin
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
                    sign       <= 1'b1;
                    need_digit <= 1'b1;
                    acc        <= '0;
                    state      <= NUM;
`else
                    state <= DRAIN;
`endif
                  end else if (in_byte != CH_SP) begin
                    state <= DRAIN;
                  end
                end
                NUM: begin
                  if (is_digit && !ovf) begin
                    acc <= acc_next;
`ifdef PRINTF_LINE_DECODER_SIGNED_EN
                    need_digit <= 1'b0;
`endif
                  end else begin
                    state <= DRAIN;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_printf_line_decoder.sv
// Directed self-checking bench for printf_line_decoder at WIDTH=5.
module tb_printf_line_decoder;

  localparam int unsigned W = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_error;
  logic [15:0]  line_count;

  int checks = 0;
  int errors = 0;
  int exp_lines = 0;
  logic [W:0] results[$];

  printf_line_decoder #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_error  (out_error),
    .line_count (line_count)
  );

  always #5 clock = ~clock;

  // A result is handed off at the rising edge following a negedge where valid && ready.
  always @(negedge clock)
    if (!reset && out_valid && out_ready) results.push_back({out_error, out_value});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input byte b);
    logic was_ready;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 50; i++) begin
      was_ready = in_ready;
      @(posedge clock);
      #1;
      if (was_ready) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 40; i++) begin
      if (results.size() >= n) return;
      @(negedge clock);
    end
    check("result_timeout", results.size(), n);
  endtask

  task automatic run_line(input string tag, input string s, input logic [W-1:0] ev, input logic ee);
    logic [W:0] r;
    send_line(s);
    wait_results(1);
    @(posedge clock);
    #1;
    if (results.size() != 0) begin
      r = results.pop_front();
      check({tag, "_value"}, r[W-1:0], ev);
      check({tag, "_error"}, r[W], ee);
      exp_lines++;
    end
    check({tag, "_extra"}, results.size(), 0);
    check({tag, "_lines"}, line_count, exp_lines);
  endtask

  initial begin
    logic [W:0] r;
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_error", out_error, 0);
    check("rst_line_count", line_count, 0);

    // Basic line with cycle-exact latency
    send_line("i1 7\n");
    check("basic_valid_n1", out_valid, 1);
    check("basic_value", out_value, 5'h07);
    check("basic_error", out_error, 0);
    check("basic_in_ready_emit", in_ready, 0);
    @(posedge clock); #1;
    check("basic_valid_after", out_valid, 0);
    check("basic_in_ready_after", in_ready, 1);
    check("basic_lines", line_count, 1);
    check("basic_results", results.size(), 1);
    results.delete();
    exp_lines = 1;

    // Backpressure: second line's first byte held while EMIT waits
    out_ready = 1'b0;
    send_line("ab 12\n");
    in_valid = 1'b1;
    in_byte  = "c";
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_value", out_value, 12);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send_line("c 3\n");
    wait_results(2);
    @(posedge clock); #1;
    check("bp_count", results.size(), 2);
    if (results.size() == 2) begin
      r = results.pop_front();
      check("bp_first", r, {1'b0, 5'd12});
      r = results.pop_front();
      check("bp_second", r, {1'b0, 5'd3});
    end
    results.delete();
    exp_lines += 2;
    check("bp_lines", line_count, exp_lines);

    // Overflow boundary and leading zeros
    run_line("ovf31", "a 31\n", 5'd31, 1'b0);
    run_line("ovf32", "a 32\n", 5'd0, 1'b1);
    run_line("ovf0031", "a 0031\n", 5'd31, 1'b0);
    run_line("ovfbig", "a 99999\n", 5'd0, 1'b1);

    // Malformed lines, CR tolerance, empty tag
    run_line("no_field", "i1\n", 5'd0, 1'b1);
    run_line("empty_field", "i1 \n", 5'd0, 1'b1);
    run_line("trailing", "i1 7x\n", 5'd0, 1'b1);
    run_line("cr", "i1 \r7\r\n", 5'd7, 1'b0);
    run_line("empty_tag", " 5\n", 5'd5, 1'b0);
    run_line("multi_space", "t  25\n", 5'd25, 1'b0);

`ifdef PRINTF_LINE_DECODER_SIGNED_EN
    run_line("neg5", "x -5\n", 5'h1B, 1'b0);
    run_line("neg16", "x -16\n", 5'h10, 1'b0);
    run_line("neg17", "x -17\n", 5'd0, 1'b1);
    run_line("neg_empty", "x -\n", 5'd0, 1'b1);
    run_line("neg0", "x -0\n", 5'd0, 1'b0);
`else
    run_line("minus_unsigned", "x -5\n", 5'd0, 1'b1);
`endif

    // Reset mid-line discards the partial line and clears line_count
    send_line("i1 4");
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_lines", line_count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_results", results.size(), 0);
    exp_lines = 0;
    run_line("after_rst", "z 9\n", 5'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
